// File: rtl/ni_param_v2.sv
// ni_param_v2: GPU network interface between one GPU port and its leaf router.
// Translates GPU IDs to routing addresses and back by adding or replacing the
// header, buffers each direction in a FIFO, and can loop local traffic back.
// It drops flits with invalid destinations and counts them.

// Power-of-two FIFO. Pointers wrap naturally and the count is one bit wider.
module ni_param_v2_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_data = mem_q[rd_ptr_q];

    // Next pointer, count and storage state; push and pop together keep the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module ni_param_v2 #(
    parameter int unsigned GPU_ID      = 28,
    parameter int unsigned NUM_GPUS    = 32,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned HEADER_W    = 6,
    parameter int unsigned ADDR_OFFSET = 3,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned LOOPBACK_EN = 1,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    gpu_data_in,
    input  logic                 gpu_valid_in,
    output logic                 gpu_ready_out,
    output logic [DATA_W-1:0]    gpu_data_out,
    output logic                 gpu_valid_out,
    input  logic                 gpu_ready_in,
    output logic [DATA_W-1:0]    router_data_out,
    output logic                 router_valid_out,
    input  logic                 router_ready_in,
    input  logic [DATA_W-1:0]    router_data_in,
    input  logic                 router_valid_in,
    output logic                 router_ready_out,
    output logic [ERR_CNT_W-1:0] err_bad_dest,
    output logic [ERR_CNT_W-1:0] err_misroute
);
    localparam int unsigned PAY_W = DATA_W - HEADER_W;
    localparam logic [HEADER_W-1:0] OWN_ADDR = HEADER_W'(GPU_ID + ADDR_OFFSET);
    localparam logic [HEADER_W-1:0] OWN_ID   = HEADER_W'(GPU_ID);
    localparam logic [HEADER_W-1:0] OFFSET_H = HEADER_W'(ADDR_OFFSET);

    // FIFO interconnect
    logic              g2r_push, g2r_pop, g2r_empty, g2r_full;
    logic [DATA_W-1:0] g2r_push_data, g2r_head;
    logic              r2g_push, r2g_pop, r2g_empty, r2g_full;
    logic [DATA_W-1:0] r2g_push_data, r2g_head;

    // Output registers and counters
    logic                 rout_valid_q, rout_valid_d;
    logic [DATA_W-1:0]    rout_data_q, rout_data_d;
    logic                 gout_valid_q, gout_valid_d;
    logic [DATA_W-1:0]    gout_data_q, gout_data_d;
    logic [ERR_CNT_W-1:0] bad_dest_q, bad_dest_d;
    logic [ERR_CNT_W-1:0] misroute_q, misroute_d;

    // Ingress decode
    logic [HEADER_W-1:0] g_hdr, r_hdr, head_hdr;
    logic [PAY_W-1:0]    g_pay, r_pay, head_pay;
    logic                g_accept, g_id_ok, r_accept, r_hit, r_push_rtr;
    logic                head_lb, lb_pop, eg_load, gd_load;

    assign g_hdr    = gpu_data_in[DATA_W-1 -: HEADER_W];
    assign g_pay    = gpu_data_in[PAY_W-1:0];
    assign r_hdr    = router_data_in[DATA_W-1 -: HEADER_W];
    assign r_pay    = router_data_in[PAY_W-1:0];
    assign head_hdr = g2r_head[DATA_W-1 -: HEADER_W];
    assign head_pay = g2r_head[PAY_W-1:0];

    assign gpu_ready_out    = !g2r_full;
    assign router_ready_out = !r2g_full;

    // Handshake decode, routing decisions and FIFO control for both directions.
    always_comb begin
        g_accept   = gpu_valid_in && !g2r_full;
        g_id_ok    = (32'(g_hdr) >= 32'd1) && (32'(g_hdr) <= 32'(NUM_GPUS));
        g2r_push   = g_accept && g_id_ok;
        g2r_push_data = {g_hdr + OFFSET_H, g_pay};

        r_accept   = router_valid_in && !r2g_full;
        r_hit      = (r_hdr == OWN_ADDR);
        r_push_rtr = r_accept && r_hit;

        // A loopback head waits behind router traffic and blocks egress meanwhile.
        head_lb = (LOOPBACK_EN != 0) && !g2r_empty && (head_hdr == OWN_ADDR);
        lb_pop  = head_lb && !r_push_rtr && !r2g_full;
        eg_load = !g2r_empty && !head_lb && (!rout_valid_q || router_ready_in);
        g2r_pop = eg_load || lb_pop;

        r2g_push      = r_push_rtr || lb_pop;
        r2g_push_data = r_push_rtr ? {OWN_ID, r_pay} : {OWN_ID, head_pay};
        gd_load       = !r2g_empty && (!gout_valid_q || gpu_ready_in);
        r2g_pop       = gd_load;
    end

    // Next state of both one-entry output registers and the error counters.
    always_comb begin
        rout_valid_d = rout_valid_q;
        rout_data_d  = rout_data_q;
        gout_valid_d = gout_valid_q;
        gout_data_d  = gout_data_q;
        bad_dest_d   = bad_dest_q;
        misroute_d   = misroute_q;

        if (eg_load) begin
            rout_valid_d = 1'b1;
            rout_data_d  = g2r_head;
        end else if (router_ready_in) begin
            rout_valid_d = 1'b0;
        end

        if (gd_load) begin
            gout_valid_d = 1'b1;
            gout_data_d  = r2g_head;
        end else if (gpu_ready_in) begin
            gout_valid_d = 1'b0;
        end

        if (g_accept && !g_id_ok && (bad_dest_q != '1)) begin
            bad_dest_d = bad_dest_q + ERR_CNT_W'(1);
        end
        if (r_accept && !r_hit && (misroute_q != '1)) begin
            misroute_d = misroute_q + ERR_CNT_W'(1);
        end
    end

    // Output registers and counters; reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rout_valid_q <= 1'b0;
            rout_data_q  <= '0;
            gout_valid_q <= 1'b0;
            gout_data_q  <= '0;
            bad_dest_q   <= '0;
            misroute_q   <= '0;
        end else begin
            rout_valid_q <= rout_valid_d;
            rout_data_q  <= rout_data_d;
            gout_valid_q <= gout_valid_d;
            gout_data_q  <= gout_data_d;
            bad_dest_q   <= bad_dest_d;
            misroute_q   <= misroute_d;
        end
    end

    assign router_valid_out = rout_valid_q;
    assign router_data_out  = rout_data_q;
    assign gpu_valid_out    = gout_valid_q;
    assign gpu_data_out     = gout_data_q;
    assign err_bad_dest     = bad_dest_q;
    assign err_misroute     = misroute_q;

    ni_param_v2_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_g2r (
        .clk       (clk),
        .reset     (reset),
        .push      (g2r_push),
        .push_data (g2r_push_data),
        .pop       (g2r_pop),
        .head_data (g2r_head),
        .empty     (g2r_empty),
        .full      (g2r_full)
    );

    ni_param_v2_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_r2g (
        .clk       (clk),
        .reset     (reset),
        .push      (r2g_push),
        .push_data (r2g_push_data),
        .pop       (r2g_pop),
        .head_data (r2g_head),
        .empty     (r2g_empty),
        .full      (r2g_full)
    );
endmodule

// File: tb/tb_ni_param_v2.sv
// Directed self-checking bench for ni_param_v2 with default parameters.
module tb_ni_param_v2;
    localparam int DATA_W    = 16;
    localparam int ERR_CNT_W = 8;

    logic                 clk;
    logic                 reset;
    logic [DATA_W-1:0]    gpu_data_in;
    logic                 gpu_valid_in;
    logic                 gpu_ready_out;
    logic [DATA_W-1:0]    gpu_data_out;
    logic                 gpu_valid_out;
    logic                 gpu_ready_in;
    logic [DATA_W-1:0]    router_data_out;
    logic                 router_valid_out;
    logic                 router_ready_in;
    logic [DATA_W-1:0]    router_data_in;
    logic                 router_valid_in;
    logic                 router_ready_out;
    logic [ERR_CNT_W-1:0] err_bad_dest;
    logic [ERR_CNT_W-1:0] err_misroute;

    int n_asserts = 0;
    int n_fail    = 0;

    ni_param_v2 #(
        .GPU_ID      (28),
        .NUM_GPUS    (32),
        .DATA_W      (16),
        .HEADER_W    (6),
        .ADDR_OFFSET (3),
        .FIFO_DEPTH  (8),
        .LOOPBACK_EN (1),
        .ERR_CNT_W   (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .gpu_data_in      (gpu_data_in),
        .gpu_valid_in     (gpu_valid_in),
        .gpu_ready_out    (gpu_ready_out),
        .gpu_data_out     (gpu_data_out),
        .gpu_valid_out    (gpu_valid_out),
        .gpu_ready_in     (gpu_ready_in),
        .router_data_out  (router_data_out),
        .router_valid_out (router_valid_out),
        .router_ready_in  (router_ready_in),
        .router_data_in   (router_data_in),
        .router_valid_in  (router_valid_in),
        .router_ready_out (router_ready_out),
        .err_bad_dest     (err_bad_dest),
        .err_misroute     (err_misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_gpu(input logic [DATA_W-1:0] d);
        gpu_data_in  = d;
        gpu_valid_in = 1'b1;
        for (int i = 0; i < 40 && !gpu_ready_out; i++) tick();
        chk("gpu_ready_wait", 32'(gpu_ready_out), 32'd1);
        tick();
        gpu_valid_in = 1'b0;
    endtask

    task automatic send_router(input logic [DATA_W-1:0] d);
        router_data_in  = d;
        router_valid_in = 1'b1;
        for (int i = 0; i < 40 && !router_ready_out; i++) tick();
        chk("router_ready_wait", 32'(router_ready_out), 32'd1);
        tick();
        router_valid_in = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        gpu_data_in     = '0;
        gpu_valid_in    = 1'b0;
        gpu_ready_in    = 1'b0;
        router_data_in  = '0;
        router_valid_in = 1'b0;
        router_ready_in = 1'b0;
        tick();
        tick();
        chk("rst_router_valid", 32'(router_valid_out), 32'd0);
        chk("rst_gpu_valid", 32'(gpu_valid_out), 32'd0);
        chk("rst_router_data", 32'(router_data_out), 32'd0);
        chk("rst_gpu_data", 32'(gpu_data_out), 32'd0);
        chk("rst_err_bad", 32'(err_bad_dest), 32'd0);
        chk("rst_err_mis", 32'(err_misroute), 32'd0);
        chk("rst_gpu_ready", 32'(gpu_ready_out), 32'd1);
        chk("rst_router_ready", 32'(router_ready_out), 32'd1);
        #2 reset = 1'b0;
        tick();

        // Single GPU flit, id 1 -> address 4
        router_ready_in = 1'b1;
        gpu_ready_in    = 1'b1;
        send_gpu(16'h0401);
        chk("t1_not_yet", 32'(router_valid_out), 32'd0);
        tick();
        chk("t1_valid", 32'(router_valid_out), 32'd1);
        chk("t1_data", 32'(router_data_out), 32'h1001);
        tick();
        chk("t1_pulse_once", 32'(router_valid_out), 32'd0);

        // Fill: 8 in FIFO + 1 in the output register, then drain in order
        router_ready_in = 1'b0;
        for (int i = 1; i <= 9; i++) send_gpu(16'((i << 10) | (i + 32)));
        chk("t2_ready_low", 32'(gpu_ready_out), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t2_stall_valid", 32'(router_valid_out), 32'd1);
            chk("t2_stall_data", 32'(router_data_out), 32'h1021);
        end
        router_ready_in = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            chk("t2_drain_valid", 32'(router_valid_out), 32'd1);
            chk("t2_drain_data", 32'(router_data_out), 32'(((i + 3) << 10) | (i + 32)));
            tick();
        end
        chk("t2_empty", 32'(router_valid_out), 32'd0);
        chk("t2_ready_back", 32'(gpu_ready_out), 32'd1);

        // Router ingress: own address delivered, other address counted
        send_router(16'h7C2A);
        send_router(16'h7425);
        chk("t3_gpu_valid", 32'(gpu_valid_out), 32'd1);
        chk("t3_gpu_data", 32'(gpu_data_out), 32'h702A);
        chk("t3_misroute", 32'(err_misroute), 32'd1);
        tick();
        chk("t3_gpu_done", 32'(gpu_valid_out), 32'd0);
        chk("t3_misroute_hold", 32'(err_misroute), 32'd1);

        // Invalid destinations, then counter saturation
        send_gpu(16'h0000);
        send_gpu(16'hA000);
        tick();
        chk("t4_bad_two", 32'(err_bad_dest), 32'd2);
        chk("t4_no_router", 32'(router_valid_out), 32'd0);
        for (int i = 0; i < 300; i++) send_gpu(16'hA000);
        tick();
        chk("t4_saturated", 32'(err_bad_dest), 32'd255);
        chk("t4_no_router2", 32'(router_valid_out), 32'd0);
        chk("t4_no_gpu", 32'(gpu_valid_out), 32'd0);

        // Loopback against concurrent router traffic to the same GPU
        gpu_data_in     = 16'h7055;
        gpu_valid_in    = 1'b1;
        router_data_in  = 16'h7C11;
        router_valid_in = 1'b1;
        chk("t5_gready", 32'(gpu_ready_out), 32'd1);
        chk("t5_rready", 32'(router_ready_out), 32'd1);
        tick();
        gpu_valid_in   = 1'b0;
        router_data_in = 16'h7C12;
        chk("t5_k_gv", 32'(gpu_valid_out), 32'd0);
        chk("t5_k_rv", 32'(router_valid_out), 32'd0);
        tick();
        router_valid_in = 1'b0;
        chk("t5_first_valid", 32'(gpu_valid_out), 32'd1);
        chk("t5_first_data", 32'(gpu_data_out), 32'h7011);
        chk("t5_rv1", 32'(router_valid_out), 32'd0);
        tick();
        chk("t5_second_data", 32'(gpu_data_out), 32'h7012);
        chk("t5_rv2", 32'(router_valid_out), 32'd0);
        tick();
        chk("t5_lb_valid", 32'(gpu_valid_out), 32'd1);
        chk("t5_lb_data", 32'(gpu_data_out), 32'h7055);
        chk("t5_rv3", 32'(router_valid_out), 32'd0);
        tick();
        chk("t5_done", 32'(gpu_valid_out), 32'd0);
        chk("t5_rv4", 32'(router_valid_out), 32'd0);

        // Reset with both directions partly full and inputs valid
        router_ready_in = 1'b0;
        gpu_ready_in    = 1'b0;
        for (int i = 1; i <= 4; i++) send_gpu(16'((i << 10) | 3));
        for (int i = 1; i <= 4; i++) send_router(16'(16'h7C00 | i));
        gpu_data_in     = 16'h1405;
        gpu_valid_in    = 1'b1;
        router_data_in  = 16'h7C05;
        router_valid_in = 1'b1;
        chk("t6_pre_rv", 32'(router_valid_out), 32'd1);
        chk("t6_pre_gv", 32'(gpu_valid_out), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("t6_rv", 32'(router_valid_out), 32'd0);
        chk("t6_gv", 32'(gpu_valid_out), 32'd0);
        chk("t6_rdata", 32'(router_data_out), 32'd0);
        chk("t6_gdata", 32'(gpu_data_out), 32'd0);
        chk("t6_err_bad", 32'(err_bad_dest), 32'd0);
        chk("t6_err_mis", 32'(err_misroute), 32'd0);
        tick();
        gpu_valid_in    = 1'b0;
        router_valid_in = 1'b0;
        #2 reset = 1'b0;
        tick();
        router_ready_in = 1'b1;
        gpu_ready_in    = 1'b1;
        chk("t6_gready", 32'(gpu_ready_out), 32'd1);
        chk("t6_rready", 32'(router_ready_out), 32'd1);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t6_no_stale_r", 32'(router_valid_out), 32'd0);
            chk("t6_no_stale_g", 32'(gpu_valid_out), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
